// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int          ADDRESS_LEN = 32;
    localparam int          INSTR_LEN   = 32;
    localparam logic [31:0] NOP_INSTR   = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_hold_buffer.sv
// if_hold_buffer: parks one fetched instruction and its PC+4 while the
// pipeline is frozen. Clear has priority over load.
module if_hold_buffer #(
    parameter int                   ADDR_LEN  = 32,
    parameter int                   INSTR_LEN = 32,
    parameter logic [INSTR_LEN-1:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [ADDR_LEN-1:0]  pc_i,
    input  logic [INSTR_LEN-1:0] instr_i,
    output logic [ADDR_LEN-1:0]  pc_o,
    output logic [INSTR_LEN-1:0] instr_o
);

    logic [ADDR_LEN-1:0]  pc_q;
    logic [INSTR_LEN-1:0] instr_q;

    // Buffer register: cleared to an empty NOP slot, loaded on a frozen ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (clear_i) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage. Owns the PC, issues one-outstanding req/ack reads
// to instruction memory, honours freeze, and redirects on branch_taken.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                   ADDR_LEN  = ADDRESS_LEN,
    parameter int                   INSTR_LEN = if_fetch_unit_pkg::INSTR_LEN,
    parameter logic [ADDR_LEN-1:0]  RESET_PC  = ADDR_LEN'(if_fetch_unit_pkg::RESET_PC),
    parameter logic [INSTR_LEN-1:0] NOP_INSTR = INSTR_LEN'(if_fetch_unit_pkg::NOP_INSTR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [ADDR_LEN-1:0]  branch_addr,
    output logic                 imem_req,
    output logic [ADDR_LEN-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic [ADDR_LEN-1:0]  pc,
    output logic [INSTR_LEN-1:0] instruction,
    output logic                 instr_valid,
    output logic                 fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_LEN-1:0]  pc_q, pc_d;
    logic [ADDR_LEN-1:0]  drain_addr_q, drain_addr_d;
    logic                 run_q;

    logic [ADDR_LEN-1:0]  pc_plus4;
    logic [ADDR_LEN-1:0]  branch_target;
    logic                 branch_addr_unused;

    logic                 hb_load;
    logic                 hb_clear;
    logic [ADDR_LEN-1:0]  hb_pc;
    logic [INSTR_LEN-1:0] hb_instr;

    assign pc_plus4           = pc_q + ADDR_LEN'(4);
    assign branch_target      = {branch_addr[ADDR_LEN-1:2], 2'b00};
    assign branch_addr_unused = ^branch_addr[1:0];

    if_hold_buffer #(
        .ADDR_LEN  (ADDR_LEN),
        .INSTR_LEN (INSTR_LEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_hold_buffer (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .pc_i    (pc_plus4),
        .instr_i (imem_rdata),
        .pc_o    (hb_pc),
        .instr_o (hb_instr)
    );

    // State, PC, drain address and the post-reset run flag. run_q delays the
    // first request by one cycle after reset release and kills it instantly
    // when reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            run_q        <= 1'b1;
        end
    end

    // Next-state and output logic; branch_taken overrides everything, and the
    // DRAIN address stays on the old request until memory acknowledges it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hb_load      = 1'b0;
        hb_clear     = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        pc           = '0;
        instruction  = NOP_INSTR;
        instr_valid  = 1'b0;
        fetch_busy   = 1'b0;

        if (run_q) begin
            unique case (state_q)
                FETCH: begin
                    imem_req   = 1'b1;
                    imem_addr  = pc_q;
                    fetch_busy = ~imem_ack;
                    if (branch_taken) begin
                        pc_d = branch_target;
                        if (!imem_ack) begin
                            drain_addr_d = pc_q;
                            state_d      = DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (!freeze) begin
                            instruction = imem_rdata;
                            pc          = pc_plus4;
                            instr_valid = 1'b1;
                            pc_d        = pc_plus4;
                        end else begin
                            hb_load = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        pc_d     = branch_target;
                        hb_clear = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        instruction = hb_instr;
                        pc          = hb_pc;
                        instr_valid = 1'b1;
                        if (!freeze) begin
                            pc_d    = pc_plus4;
                            state_d = FETCH;
                        end
                    end
                end

                DRAIN: begin
                    imem_req   = 1'b1;
                    imem_addr  = drain_addr_q;
                    fetch_busy = ~imem_ack;
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Performance counters: consumed instructions and stalled cycles, wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (instr_valid && !freeze) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (fetch_busy || (state_q == HOLD)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .fetch_busy   (fetch_busy)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next active edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic frz,
                         input logic br, input logic [31:0] baddr);
        imem_ack     = ack;
        imem_rdata   = rdata;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", pc); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h exp %h", instruction, NOP); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
        n_tests++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", fetch_busy); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req: got %b exp 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 32'hA000_0000 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req%0d: got %b exp 1", i, imem_req); end
            n_tests++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_addr%0d: got %h exp %h", i, imem_addr, 32'(4 * i)); end
            n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d: got %b exp 1", i, instr_valid); end
            n_tests++; if (pc !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL zw_pc%0d: got %h exp %h", i, pc, 32'(4 * i + 4)); end
            n_tests++; if (instruction !== 32'hA000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL zw_instr%0d: got %h exp %h", i, instruction, 32'hA000_0000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            n_tests++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy%0d: got %b exp 1", i, fetch_busy); end
            n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid%0d: got %b exp 0", i, instr_valid); end
            n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL lat_addr%0d: got %h exp c", i, imem_addr); end
        end
        next_cycle();
        drive(1'b1, 32'hB0B0_000C, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL lat_addr_ack: got %h exp c", imem_addr); end
        n_tests++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_ack: got %b exp 0", fetch_busy); end
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid_ack: got %b exp 1", instr_valid); end
        n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL lat_pc: got %h exp 10", pc); end
        n_tests++; if (instruction !== 32'hB0B0_000C) begin n_fail++; $display("FAIL lat_instr: got %h exp b0b0000c", instruction); end
    endtask

    task automatic test_freeze_hold();
        next_cycle();
        drive(1'b1, 32'hD000_0010, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL fz_addr: got %h exp 10", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req%0d: got %b exp 0", i, imem_req); end
            n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid%0d: got %b exp 1", i, instr_valid); end
            n_tests++; if (instruction !== 32'hD000_0010) begin n_fail++; $display("FAIL hold_instr%0d: got %h exp d0000010", i, instruction); end
            n_tests++; if (pc !== 32'h14) begin n_fail++; $display("FAIL hold_pc%0d: got %h exp 14", i, pc); end
        end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid: got %b exp 1", instr_valid); end
        n_tests++; if (pc !== 32'h14) begin n_fail++; $display("FAIL rel_pc: got %h exp 14", pc); end
        n_tests++; if (instruction !== 32'hD000_0010) begin n_fail++; $display("FAIL rel_instr: got %h exp d0000010", instruction); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_hold_req: got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL post_hold_addr: got %h exp 14", imem_addr); end
    endtask

    task automatic test_branch_drain();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 32'h1234_0000, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            n_tests++; if (imem_addr !== 32'(32'h14 + 4 * i)) begin n_fail++; $display("FAIL pre_br_addr%0d: got %h exp %h", i, imem_addr, 32'(32'h14 + 4 * i)); end
        end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_addr: got %h exp 20", imem_addr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b exp 0", instr_valid); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL br_instr: got %h exp %h", instruction, NOP); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_req: got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL drain_addr: got %h exp 20", imem_addr); end
        n_tests++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b exp 1", fetch_busy); end
        next_cycle();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_ack_valid: got %b exp 0", instr_valid); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL drain_ack_instr: got %h exp %h", instruction, NOP); end
        n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL drain_ack_addr: got %h exp 20", imem_addr); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL tgt_req: got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL tgt_addr: got %h exp 100", imem_addr); end
    endtask

    task automatic test_branch_freeze_ack();
        next_cycle();
        drive(1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bfa_valid: got %b exp 0", instr_valid); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL bfa_instr: got %h exp %h", instruction, NOP); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bfa_next_req: got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL bfa_next_addr: got %h exp 200", imem_addr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bfa_next_valid: got %b exp 0", instr_valid); end
    endtask

    task automatic test_wrap_reset();
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_br_valid: got %b exp 0", instr_valid); end
        next_cycle();
        drive(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL wr_drain_addr: got %h exp 200", imem_addr); end
        next_cycle();
        drive(1'b1, 32'hF00D_0001, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got %h exp fffffffc", imem_addr); end
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b exp 1", instr_valid); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wr_pc: got %h exp 0", pc); end
        next_cycle();
        drive(1'b1, 32'hF00D_0002, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next_addr: got %h exp 0", imem_addr); end
        n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL wr_next_pc: got %h exp 4", pc); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL wait_addr: got %h exp 4", imem_addr); end
        n_tests++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b exp 1", fetch_busy); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b exp 0", imem_req); end
        n_tests++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", fetch_busy); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rerel_req: got %b exp 0", imem_req); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL restart_req: got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL restart_addr: got %h exp 0", imem_addr); end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_zero_wait();
        test_latency();
        test_freeze_hold();
        test_branch_drain();
        test_branch_freeze_ack();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
